// File: rtl/ras_commit_pkg.sv
//==============================================================================
//  Module   : bpu_pkg
//  Purpose  : Shared branch-predictor types and constants for the commit-side
//             return address stack (entry type, restore bundle, restore FSM
//             state encoding, default stack depth).
//  Ports    : none (package)
//  Config   : _RAS_STACK_DEPTH sets the default stack depth (8 if undefined).
//             Set the depth through this macro so that the package widths and
//             the ras_commit parameters agree.
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef _RAS_STACK_DEPTH
`define _RAS_STACK_DEPTH 8
`endif

package bpu_pkg;

  localparam int RAS_STACK_DEPTH = `_RAS_STACK_DEPTH;
  localparam int RAS_PTR_WIDTH   = $clog2(RAS_STACK_DEPTH);

  // Word address of a return target.
  typedef logic [31:2] ras_addr_t;

  // One write into the front-end RAS.
  typedef struct packed {
    logic                     valid;
    logic [RAS_PTR_WIDTH-1:0] idx;
    ras_addr_t                data;
  } ras_restore_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } ras_rst_state_e;

  // Return address of a call: the word after the call, wrapping at 2^30.
  function automatic ras_addr_t ras_ret_addr(input ras_addr_t pc);
    return pc + 30'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ras_commit_if.sv
//==============================================================================
//  Module   : ras_commit_if
//  Purpose  : Commit-side RAS bundle: retire-time call/return information and
//             the restore port towards the speculative front-end RAS.
//  Ports    : master - drives commit_*/flush_i, observes restore_*/busy_o
//             slave  - the commit RAS itself (consumes commit, drives restore)
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ras_commit_if #(
  parameter int PTR_WIDTH = 3
);
  import bpu_pkg::*;

  logic                 commit_call_i;
  logic                 commit_ret_i;
  ras_addr_t            commit_pc_i;
  logic                 flush_i;

  logic                 restore_valid_o;
  logic [PTR_WIDTH-1:0] restore_idx_o;
  ras_addr_t            restore_data_o;
  logic                 restore_done_o;
  logic [PTR_WIDTH-1:0] restore_ptr_o;
  logic [PTR_WIDTH:0]   restore_cnt_o;
  logic                 busy_o;

  modport master (
    output commit_call_i, commit_ret_i, commit_pc_i, flush_i,
    input  restore_valid_o, restore_idx_o, restore_data_o,
           restore_done_o, restore_ptr_o, restore_cnt_o, busy_o
  );

  modport slave (
    input  commit_call_i, commit_ret_i, commit_pc_i, flush_i,
    output restore_valid_o, restore_idx_o, restore_data_o,
           restore_done_o, restore_ptr_o, restore_cnt_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/ras_commit_restore_fsm.sv
//==============================================================================
//  Module   : ras_restore_fsm
//  Purpose  : Sequencer for replaying the committed RAS into the front end.
//             Walks idx over every physical entry, then one DONE cycle.
//             Any start while busy restarts the walk from entry 0.
//  Ports    : clk, rst      - clock, async active-high reset
//             start_i       - flush, or a commit landing while busy
//             depth_i       - number of entries to walk
//             state_o/idx_o - current state and entry index
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ras_restore_fsm
  import bpu_pkg::*;
#(
  parameter int PTR_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [PTR_WIDTH:0]   depth_i,
  output ras_rst_state_e       state_o,
  output logic [PTR_WIDTH-1:0] idx_o
);

  ras_rst_state_e       state_q, state_d;
  logic [PTR_WIDTH-1:0] idx_q, idx_d;
  logic                 last_entry;

  assign last_entry = ({1'b0, idx_q} == (depth_i - (PTR_WIDTH+1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = COPY;
          idx_d   = '0;
        end
      end
      COPY: begin
        if (start_i) begin
          idx_d = '0;
        end else if (last_entry) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + PTR_WIDTH'(1);
        end
      end
      DONE: begin
        if (start_i) begin
          state_d = COPY;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign state_o = state_q;
  assign idx_o   = idx_q;

endmodule

`default_nettype wire

// File: rtl/ras_commit.sv
//==============================================================================
//  Module   : ras_commit
//  Purpose  : Architectural return address stack updated by retiring
//             calls/returns. On flush it replays every physical entry plus
//             the committed ptr/cnt into the front-end RAS.
//  Ports    : clk, rst - clock, async active-high reset
//             ras      - ras_commit_if.slave (commit inputs, restore outputs)
//             perf_ovf_o/perf_udf_o - overflow/underflow event counters
//                        (only with RAS_PERF_CNT_EN defined)
//  Config   : RAS_PERF_CNT_EN - adds the 32-bit performance counters.
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ras_commit
  import bpu_pkg::*;
#(
  parameter int STACK_DEPTH = RAS_STACK_DEPTH,
  parameter int PTR_WIDTH   = $clog2(STACK_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  ras_commit_if.slave ras
`ifdef RAS_PERF_CNT_EN
  ,
  output logic [31:0] perf_ovf_o,
  output logic [31:0] perf_udf_o
`endif
);

  localparam logic [PTR_WIDTH:0] DEPTH = (PTR_WIDTH+1)'(STACK_DEPTH);

  ras_addr_t            stk_q [STACK_DEPTH];
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic [PTR_WIDTH:0]   cnt_q, cnt_d;

  logic                 empty, full;
  logic                 do_push, do_replace, do_pop;
  logic                 wr_en;
  logic [PTR_WIDTH-1:0] wr_idx;
  ras_addr_t            wr_data;

  ras_rst_state_e       state;
  logic [PTR_WIDTH-1:0] copy_idx;
  logic                 busy;
  logic                 start;
  ras_restore_t         restore;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH);

  // A tail call on an empty stack has no top to replace, so it pushes.
  assign do_push    = ras.commit_call_i & (~ras.commit_ret_i | empty);
  assign do_replace = ras.commit_call_i &   ras.commit_ret_i & ~empty;
  assign do_pop     = ras.commit_ret_i  &  ~ras.commit_call_i & ~empty;

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = ras_ret_addr(ras.commit_pc_i);
    if (do_push) begin
      // Depth is a power of two, so the pointer wraps naturally; when full
      // the slot at ptr holds the oldest entry and is overwritten.
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_WIDTH'(1);
      if (!full) begin
        cnt_d = cnt_q + (PTR_WIDTH+1)'(1);
      end
    end else if (do_replace) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q - PTR_WIDTH'(1);
    end else if (do_pop) begin
      ptr_d = ptr_q - PTR_WIDTH'(1);
      cnt_d = cnt_q - (PTR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage carries no reset: contents beyond cnt are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      stk_q[wr_idx] <= wr_data;
    end
  end

  // Any commit while a restore is in flight may have changed what was
  // already sent, so the whole copy starts over with the updated state.
  assign busy  = (state != IDLE);
  assign start = ras.flush_i | (busy & (ras.commit_call_i | ras.commit_ret_i));

  ras_restore_fsm #(
    .PTR_WIDTH (PTR_WIDTH)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .depth_i (DEPTH),
    .state_o (state),
    .idx_o   (copy_idx)
  );

  // The copy reads the live array, so writes are seen one cycle later.
  always_comb begin
    restore = '0;
    if (state == COPY) begin
      restore.valid = 1'b1;
      restore.idx   = RAS_PTR_WIDTH'(copy_idx);
      restore.data  = stk_q[copy_idx];
    end
  end

  assign ras.restore_valid_o = restore.valid;
  assign ras.restore_idx_o   = PTR_WIDTH'(restore.idx);
  assign ras.restore_data_o  = restore.data;
  assign ras.restore_done_o  = (state == DONE);
  assign ras.restore_ptr_o   = (state == DONE) ? ptr_q : '0;
  assign ras.restore_cnt_o   = (state == DONE) ? cnt_q : '0;
  assign ras.busy_o          = busy;

`ifdef RAS_PERF_CNT_EN
  logic [31:0] perf_ovf_q, perf_ovf_d;
  logic [31:0] perf_udf_q, perf_udf_d;

  // Overflow: a push that evicts the oldest entry. Underflow: a plain
  // return with nothing on the stack.
  always_comb begin
    perf_ovf_d = perf_ovf_q;
    perf_udf_d = perf_udf_q;
    if (do_push && full) begin
      perf_ovf_d = perf_ovf_q + 32'd1;
    end
    if (ras.commit_ret_i && !ras.commit_call_i && empty) begin
      perf_udf_d = perf_udf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ovf_q <= '0;
      perf_udf_q <= '0;
    end else begin
      perf_ovf_q <= perf_ovf_d;
      perf_udf_q <= perf_udf_d;
    end
  end

  assign perf_ovf_o = perf_ovf_q;
  assign perf_udf_o = perf_udf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ras_commit.sv
//==============================================================================
//  Module   : tb_ras_commit
//  Purpose  : Self-checking bench for ras_commit: directed scenarios, a
//             vector table of commit operations, and random commit traffic
//             compared against a behavioural stack model.
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ras_commit;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ras_commit_if #(.PTR_WIDTH(3)) rif ();

`ifdef RAS_PERF_CNT_EN
  logic [31:0] perf_ovf, perf_udf;
`endif

  ras_commit #(.STACK_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .ras (rif)
`ifdef RAS_PERF_CNT_EN
    ,
    .perf_ovf_o (perf_ovf),
    .perf_udf_o (perf_udf)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: plain array with integer pointer arithmetic.
  logic [29:0] m_stk [D];
  int          m_ptr, m_cnt;
  int unsigned m_ovf, m_udf;

  // What the last restore delivered.
  logic [29:0] cap_data [D];
  int          cap_ptr, cap_cnt;

  typedef struct {
    bit          call;
    bit          ret;
    logic [29:0] pc;
    int          exp_ptr;
    int          exp_cnt;
    bit          chk_top;
    logic [29:0] exp_top;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_cnt = 0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic model_commit(input bit c, input bit r, input logic [29:0] pc);
    logic [29:0] ra;
    ra = pc + 30'd1;
    if (c && (!r || m_cnt == 0)) begin
      if (m_cnt == D) m_ovf++;
      m_stk[m_ptr] = ra;
      m_ptr = (m_ptr + 1) % D;
      if (m_cnt < D) m_cnt++;
    end else if (c && r) begin
      m_stk[(m_ptr + D - 1) % D] = ra;
    end else if (r) begin
      if (m_cnt > 0) begin
        m_ptr = (m_ptr + D - 1) % D;
        m_cnt--;
      end else begin
        m_udf++;
      end
    end
  endtask

  task automatic commit(input bit c, input bit r, input logic [29:0] pc);
    rif.commit_call_i = c;
    rif.commit_ret_i  = r;
    rif.commit_pc_i   = pc;
    tick();
    model_commit(c, r, pc);
    rif.commit_call_i = 1'b0;
    rif.commit_ret_i  = 1'b0;
    rif.commit_pc_i   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rif.commit_call_i = 1'b0;
    rif.commit_ret_i  = 1'b0;
    rif.commit_pc_i   = '0;
    rif.flush_i       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Called in the first copy cycle; checks all entries, then done and idle.
  task automatic run_copy();
    bit vm [D];
    for (int j = 0; j < D; j++) vm[j] = 1'b0;
    for (int j = 0; j < m_cnt; j++) vm[(m_ptr - 1 - j + 2 * D) % D] = 1'b1;
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      chk("copy_valid", 64'(rif.restore_valid_o), 64'd1);
      chk("copy_idx",   64'(rif.restore_idx_o),   64'(k));
      chk("copy_busy",  64'(rif.busy_o),          64'd1);
      chk("copy_done",  64'(rif.restore_done_o),  64'd0);
      cap_data[k] = rif.restore_data_o;
      if (vm[k]) chk($sformatf("copy_data[%0d]", k), 64'(rif.restore_data_o), 64'(m_stk[k]));
      tick();
    end
    @(negedge clk);
    chk("done_pulse", 64'(rif.restore_done_o),  64'd1);
    chk("done_busy",  64'(rif.busy_o),          64'd1);
    chk("done_valid", 64'(rif.restore_valid_o), 64'd0);
    chk("done_idx",   64'(rif.restore_idx_o),   64'd0);
    chk("done_data",  64'(rif.restore_data_o),  64'd0);
    chk("done_ptr",   64'(rif.restore_ptr_o),   64'(m_ptr));
    chk("done_cnt",   64'(rif.restore_cnt_o),   64'(m_cnt));
    cap_ptr = int'(rif.restore_ptr_o);
    cap_cnt = int'(rif.restore_cnt_o);
    tick();
    @(negedge clk);
    chk("post_busy", 64'(rif.busy_o),         64'd0);
    chk("post_done", 64'(rif.restore_done_o), 64'd0);
    chk("post_ptr",  64'(rif.restore_ptr_o),  64'd0);
    chk("post_cnt",  64'(rif.restore_cnt_o),  64'd0);
`ifdef RAS_PERF_CNT_EN
    chk("perf_ovf", 64'(perf_ovf), 64'(m_ovf));
    chk("perf_udf", 64'(perf_udf), 64'(m_udf));
`endif
  endtask

  task automatic restore();
    rif.flush_i = 1'b1;
    tick();
    rif.flush_i = 1'b0;
    run_copy();
  endtask

  initial begin
    int done_seen;
    int top;

    tbl[0] = '{1'b0, 1'b1, 30'h0,         0, 0, 1'b0, 30'h0};
    tbl[1] = '{1'b1, 1'b1, 30'h40,        1, 1, 1'b1, 30'h41};
    tbl[2] = '{1'b1, 1'b0, 30'h200,       2, 2, 1'b1, 30'h201};
    tbl[3] = '{1'b1, 1'b1, 30'h500,       2, 2, 1'b1, 30'h501};
    tbl[4] = '{1'b0, 1'b1, 30'h0,         1, 1, 1'b1, 30'h41};
    tbl[5] = '{1'b0, 1'b1, 30'h0,         0, 0, 1'b0, 30'h0};
    tbl[6] = '{1'b1, 1'b0, 30'h3FFF_FFFF, 1, 1, 1'b1, 30'h0};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid", 64'(rif.restore_valid_o), 64'd0);
    chk("rst_idx",   64'(rif.restore_idx_o),   64'd0);
    chk("rst_data",  64'(rif.restore_data_o),  64'd0);
    chk("rst_done",  64'(rif.restore_done_o),  64'd0);
    chk("rst_ptr",   64'(rif.restore_ptr_o),   64'd0);
    chk("rst_cnt",   64'(rif.restore_cnt_o),   64'd0);
    chk("rst_busy",  64'(rif.busy_o),          64'd0);

    // Three calls then restore
    commit(1'b1, 1'b0, 30'h100);
    commit(1'b1, 1'b0, 30'h200);
    commit(1'b1, 1'b0, 30'h300);
    restore();
    chk("three_e0",  64'(cap_data[0]), 64'h101);
    chk("three_e1",  64'(cap_data[1]), 64'h201);
    chk("three_e2",  64'(cap_data[2]), 64'h301);
    chk("three_ptr", 64'(cap_ptr), 64'd3);
    chk("three_cnt", 64'(cap_cnt), 64'd3);

    // Overflow: ten calls into an eight-deep stack
    do_reset();
    for (int n = 'h10; n <= 'h19; n++) commit(1'b1, 1'b0, 30'(n));
    restore();
    chk("ovf_e0",  64'(cap_data[0]), 64'h19);
    chk("ovf_e1",  64'(cap_data[1]), 64'h1A);
    chk("ovf_e7",  64'(cap_data[7]), 64'h18);
    chk("ovf_ptr", 64'(cap_ptr), 64'd2);
    chk("ovf_cnt", 64'(cap_cnt), 64'd8);
`ifdef RAS_PERF_CNT_EN
    chk("ovf_perf", 64'(perf_ovf), 64'd2);
`endif

    // Vector table of commit operations from reset
    do_reset();
    for (int i = 0; i < 7; i++) begin
      commit(tbl[i].call, tbl[i].ret, tbl[i].pc);
      restore();
      chk($sformatf("tbl%0d_ptr", i), 64'(cap_ptr), 64'(tbl[i].exp_ptr));
      chk($sformatf("tbl%0d_cnt", i), 64'(cap_cnt), 64'(tbl[i].exp_cnt));
      if (tbl[i].chk_top) begin
        top = (tbl[i].exp_ptr + D - 1) % D;
        chk($sformatf("tbl%0d_top", i), 64'(cap_data[top]), 64'(tbl[i].exp_top));
      end
`ifdef RAS_PERF_CNT_EN
      if (i == 0) chk("udf_perf", 64'(perf_udf), 64'd1);
`endif
    end

    // Commit during copy at idx 4 restarts the copy
    commit(1'b1, 1'b0, 30'h600);
    rif.flush_i = 1'b1;
    tick();
    rif.flush_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("pre_restart_idx", 64'(rif.restore_idx_o), 64'(k));
      tick();
    end
    @(negedge clk);
    chk("restart_at_idx4", 64'(rif.restore_idx_o), 64'd4);
    rif.commit_call_i = 1'b1;
    rif.commit_pc_i   = 30'h700;
    tick();
    rif.commit_call_i = 1'b0;
    rif.commit_pc_i   = '0;
    model_commit(1'b1, 1'b0, 30'h700);
    run_copy();
    chk("restart_ptr", 64'(cap_ptr), 64'd3);
    chk("restart_cnt", 64'(cap_cnt), 64'd3);

    // Reset in the middle of a copy
    rif.flush_i = 1'b1;
    tick();
    rif.flush_i = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    @(negedge clk);
    chk("midrst_idx3", 64'(rif.restore_idx_o), 64'd3);
    rst = 1'b1;
    #1;
    chk("midrst_busy",  64'(rif.busy_o),          64'd0);
    chk("midrst_valid", 64'(rif.restore_valid_o), 64'd0);
    chk("midrst_done",  64'(rif.restore_done_o),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    done_seen = 0;
    for (int k = 0; k < D + 3; k++) begin
      @(negedge clk);
      if (rif.restore_done_o || rif.busy_o) done_seen++;
      tick();
    end
    chk("midrst_no_done", 64'(done_seen), 64'd0);
    restore();
    chk("midrst_ptr", 64'(cap_ptr), 64'd0);
    chk("midrst_cnt", 64'(cap_cnt), 64'd0);

    // Random commit traffic against the model
    do_reset();
    for (int it = 0; it < 25; it++) begin
      int nops;
      nops = $urandom_range(1, 12);
      for (int o = 0; o < nops; o++) begin
        commit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 30'($urandom));
      end
      restore();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
